// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES block type and beat-to-block bit mapping
package des_pkg;

    localparam int DES_BLK_W = 64;

    typedef logic [DES_BLK_W-1:0] des_block_t;

    // Beat k, bit b lands on block bit k*in_w + (in_w-1-b): first beat's MSB is DES bit 1.
    function automatic logic [5:0] bit_index(input int beat, input int bit_pos, input int in_w);
        int idx;
        idx = beat * in_w + (in_w - 1 - bit_pos);
        return idx[5:0];
    endfunction

endpackage

// File: rtl/des_block_loader.sv
// rtl/des_block_loader.sv - double-buffered beat-to-64-bit DES block assembler
// Optional early completion input in_last is enabled by defining DES_LOADER_LAST_EN.
module des_block_loader
    import des_pkg::*;
#(
    parameter int IN_W = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_valid,
`ifdef DES_LOADER_LAST_EN
    input  logic                 in_last,
`endif
    output logic                 in_ready,
    output logic [DES_BLK_W-1:0] pt_out,
    output logic                 pt_valid,
    input  logic                 pt_ready,
    output logic [15:0]          blk_cnt
);

    localparam int BEATS = DES_BLK_W / IN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt;
    des_block_t       asm_reg;
    des_block_t       asm_next;
    logic             asm_full;
    logic             last_hit;
    logic             accept;
    logic             blk_done;
    logic             xfer;
    logic             slot_free;
    logic             load_new;

`ifdef DES_LOADER_LAST_EN
    assign last_hit = in_last;
`else
    assign last_hit = 1'b0;
`endif

    assign in_ready  = !asm_full;
    assign accept    = in_valid && in_ready && !flush;
    assign blk_done  = accept && ((cnt == CNT_LAST) || last_hit);
    assign xfer      = pt_valid && pt_ready;
    assign slot_free = !pt_valid || pt_ready;
    assign load_new  = blk_done && slot_free;

    always_comb begin
        asm_next = asm_reg;
        for (int b = 0; b < IN_W; b++) begin
            asm_next[bit_index(int'(cnt), b, IN_W)] = in_data[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            asm_reg  <= '0;
            asm_full <= 1'b0;
            pt_out   <= '0;
            pt_valid <= 1'b0;
            blk_cnt  <= 16'd0;
        end else begin
            if (xfer) begin
                blk_cnt <= blk_cnt + 16'd1;
            end

            if (flush) begin
                cnt      <= '0;
                asm_reg  <= '0;
                asm_full <= 1'b0;
            end else if (asm_full) begin
                // Held block drains into the output slot as soon as it frees.
                if (xfer) begin
                    pt_out   <= asm_reg;
                    asm_reg  <= '0;
                    asm_full <= 1'b0;
                end
            end else if (accept) begin
                if (blk_done) begin
                    cnt <= '0;
                    if (slot_free) begin
                        pt_out  <= asm_next;
                        asm_reg <= '0;
                    end else begin
                        asm_reg  <= asm_next;
                        asm_full <= 1'b1;
                    end
                end else begin
                    cnt     <= cnt + CNT_W'(1);
                    asm_reg <= asm_next;
                end
            end

            if (load_new || (asm_full && xfer && !flush)) begin
                pt_valid <= 1'b1;
            end else if (xfer) begin
                pt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_block_loader.sv
// tb/tb_des_block_loader.sv - scoreboard bench for des_block_loader (IN_W=8 main, IN_W=64 wrap)
module tb_des_block_loader;

    localparam int BEATS = 8;
`ifdef DES_LOADER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [7:0]  in_data;
    logic        in_valid;
`ifdef DES_LOADER_LAST_EN
    logic        in_last;
    logic        w_last;
`endif
    logic        in_ready;
    logic [63:0] pt_out;
    logic        pt_valid;
    logic        pt_ready;
    logic [15:0] blk_cnt;

    logic        w_rst_n;
    logic        w_flush;
    logic [63:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_out;
    logic        w_pv;
    logic        w_pready;
    logic [15:0] w_cnt;
    logic        w_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_deliv = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  partial[$];

    logic        prev_hold = 1'b0;
    logic [63:0] prev_out;

    always #5 clk = ~clk;

    des_block_loader #(.IN_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
`ifdef DES_LOADER_LAST_EN
        .in_last  (in_last),
`endif
        .in_ready (in_ready),
        .pt_out   (pt_out),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .blk_cnt  (blk_cnt)
    );

    des_block_loader #(.IN_W(64)) dut_w (
        .clk      (clk),
        .rst_n    (w_rst_n),
        .flush    (w_flush),
        .in_data  (w_data),
        .in_valid (w_valid),
`ifdef DES_LOADER_LAST_EN
        .in_last  (w_last),
`endif
        .in_ready (w_ready),
        .pt_out   (w_out),
        .pt_valid (w_pv),
        .pt_ready (w_pready),
        .blk_cnt  (w_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: each accepted byte is bit-reversed and placed at byte lane k.
    task automatic model_accept(input logic [7:0] d, input logic l);
        logic [63:0] blk;
        logic [7:0]  r;
        partial.push_back(d);
        if (partial.size() == BEATS || (LAST_EN && l)) begin
            blk = 64'd0;
            foreach (partial[k]) begin
                r = {<<{partial[k]}};
                blk |= {56'd0, r} << (8 * k);
            end
            exp_q.push_back(blk);
            partial.delete();
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic f, input logic r);
        logic acc;
        in_valid = v;
        in_data  = d;
        flush    = f;
        pt_ready = f ? 1'b0 : r;
`ifdef DES_LOADER_LAST_EN
        in_last  = l;
`endif
        @(negedge clk);
        acc = v && in_ready && !f;
        @(posedge clk);
        #1;
        if (f) begin
            if (exp_q.size() == 2) exp_q.delete(exp_q.size() - 1);
            partial.delete();
        end else if (acc) begin
            model_accept(d, l);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {63'd0, pt_valid}, 64'd1);
                chk("hold_data", pt_out, prev_out);
            end
            if (pt_valid && pt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_block", pt_out, 64'hx);
                end else begin
                    chk("sb_block", pt_out, exp_q.pop_front());
                end
                n_deliv++;
            end
            prev_hold = pt_valid && !pt_ready;
            prev_out  = pt_out;
        end
    end

    initial begin
        logic [63:0] wexp;
        w_rst_n  = 1'b0;
        w_flush  = 1'b0;
        w_valid  = 1'b0;
        w_data   = 64'd0;
        w_pready = 1'b1;
`ifdef DES_LOADER_LAST_EN
        w_last   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 w_rst_n = 1'b1;
        w_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            w_data = {$urandom(), $urandom()};
            wexp   = {<<{w_data}};
            @(posedge clk);
            #1;
            chk("w_block", w_out, wexp);
        end
        w_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("w_cnt_ffff", {48'd0, w_cnt}, 64'h0000_0000_0000_ffff);
        chk("w_idle", {63'd0, w_pv}, 64'd0);
        w_valid = 1'b1;
        w_data  = {$urandom(), $urandom()};
        @(posedge clk);
        #1 w_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("w_cnt_wrap", {48'd0, w_cnt}, 64'd0);
        w_done = 1'b1;
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        pt_ready = 1'b0;
`ifdef DES_LOADER_LAST_EN
        in_last  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_pt_valid", {63'd0, pt_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        chk("rst_pt_out", pt_out, 64'd0);

        // Single block, latency and one-cycle valid
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        chk("t1_latency_valid", {63'd0, pt_valid}, 64'd1);
        chk("t1_value", pt_out, 64'h10E060A020C04080);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_drop", {63'd0, pt_valid}, 64'd0);
        chk("t1_blk_cnt", {48'd0, blk_cnt}, 64'd1);

        // Backpressure fills both buffers
        for (int i = 0; i < 16; i++) cycle(1'b1, (i < 8) ? 8'hFF : 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("t2_first_held", pt_out, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("t2_still_full", {63'd0, in_ready}, 64'd0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("t2_second_out", pt_out, 64'd0);
        chk("t2_second_valid", {63'd0, pt_valid}, 64'd1);
        chk("t2_in_ready_back", {63'd0, in_ready}, 64'd1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("t2_blk_cnt", {48'd0, blk_cnt}, 64'd3);

        // Flush discards a partial block
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
        chk("t3_flush_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        chk("t3_value", pt_out, 64'h10E060A020C04080);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("t3_blk_cnt", {48'd0, blk_cnt}, 64'd4);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 10) < 6, 8'($urandom), ($urandom % 8) == 0,
                  ($urandom % 40) == 0, ($urandom % 10) < 7);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_blk_cnt", {48'd0, blk_cnt}, 64'(n_deliv[15:0]));

        // Async reset while one block is stalled at the output and another is partial
        for (int i = 0; i < 11; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pt_valid", {63'd0, pt_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        exp_q.delete();
        partial.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        chk("arst_recover_value", pt_out, 64'h10E060A020C04080);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("arst_recover_cnt", {48'd0, blk_cnt}, 64'd1);

`ifdef DES_LOADER_LAST_EN
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
        chk("last_value", pt_out, 64'h0000_0000_0000_01FF);
        chk("last_valid", {63'd0, pt_valid}, 64'd1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 80000 && !w_done; i++) @(posedge clk);
        if (!w_done) chk("wrap_timeout", 64'd0, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
